// File: rtl/zvc_decompressor.sv
// zvc_decompressor
//   Re-expands a zero-value-compressed LIFM line and its mapping-table line.
//   Each kept word is moved back to the lane given by its mask bit. Lanes whose
//   mask bit is clear come out as zero bubbles. Two-stage elastic pipeline
//   with valid/ready handshakes on both sides:
//     S1 registers the compressed line, its mask and per-lane prefix counts.
//     S2 registers the expanded line and the nonzero count.
//
// Ports
//   clk, reset                   clock (rising edge), async active-high reset
//   in_valid / in_ready          input handshake
//   lifm_comp, mt_comp, mask     compressed words, compressed MT entries, lane mask
//   out_valid / out_ready        output handshake
//   lifm_line, mt_line, nnz      expanded words, expanded MT entries, popcount(mask)
//   err                          sticky packing error (0 unless check build)
//
// Build option
//   ZVC_DECOMP_CHECK_EN: when defined, err sets if any compressed lane at or
//   above popcount(mask) is nonzero. The flag stays set until reset. The
//   datapath is the same in both builds.

module zvc_decompressor #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 128,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_comp,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
  input  logic [LINE_SIZE-1:0]                          mask,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_line,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
  output logic [CNT_WIDTH-1:0]                          nnz,
  output logic                                          err
);

  localparam int ENTRY_W = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int IDX_W   = $clog2(LINE_SIZE);
  localparam int LIFM_W  = LINE_SIZE * WORD_WIDTH;
  localparam int MT_W    = LINE_SIZE * ENTRY_W;

  logic              s1_valid;
  logic              s2_valid;
  logic [LIFM_W-1:0] s1_lifm;
  logic [MT_W-1:0]   s1_mt;
  logic [LINE_SIZE-1:0] s1_mask;
  logic [IDX_W-1:0]  s1_pfx [LINE_SIZE];
  logic [CNT_WIDTH-1:0] s1_cnt;

  logic [IDX_W-1:0]  pfx_d [LINE_SIZE];
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [LIFM_W-1:0] exp_lifm;
  logic [MT_W-1:0]   exp_mt;
  logic [IDX_W-1:0]  sel;
  logic              adv;

  // S2 can take a new line when it is empty or its line is leaving now.
  // S1 moves into S2 under the same condition, so in_ready also depends on
  // out_ready through a combinational path.
  assign adv       = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv;
  assign out_valid = s2_valid;

  // Exclusive prefix popcount of the incoming mask. Each prefix fits in
  // IDX_W bits because it never exceeds LINE_SIZE-1. The total count needs
  // the full CNT_WIDTH.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      pfx_d[i] = cnt_d[IDX_W-1:0];
      cnt_d    = cnt_d + {{(CNT_WIDTH-1){1'b0}}, mask[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_lifm  <= '0;
      s1_mt    <= '0;
      s1_mask  <= '0;
      s1_cnt   <= '0;
      for (int i = 0; i < LINE_SIZE; i++) s1_pfx[i] <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lifm <= lifm_comp;
        s1_mt   <= mt_comp;
        s1_mask <= mask;
        s1_cnt  <= cnt_d;
        for (int i = 0; i < LINE_SIZE; i++) s1_pfx[i] <= pfx_d[i];
      end
    end
  end

  // Each lane that has a kept entry reads compressed slot P[i]. Every other
  // lane is a zero bubble.
  always_comb begin
    exp_lifm = '0;
    exp_mt   = '0;
    sel      = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      sel = s1_pfx[i];
      if (s1_mask[i]) begin
        exp_lifm[i*WORD_WIDTH +: WORD_WIDTH] = s1_lifm[int'(sel)*WORD_WIDTH +: WORD_WIDTH];
        exp_mt[i*ENTRY_W +: ENTRY_W]         = s1_mt[int'(sel)*ENTRY_W +: ENTRY_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      lifm_line <= '0;
      mt_line   <= '0;
      nnz       <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        lifm_line <= exp_lifm;
        mt_line   <= exp_mt;
        nnz       <= s1_cnt;
      end
    end
  end

`ifdef ZVC_DECOMP_CHECK_EN
  logic chk_bad;

  // Slots at or above the kept count should be empty. Nonzero data there
  // means the compressor packed the line incorrectly.
  always_comb begin
    chk_bad = 1'b0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      if ((i >= int'(s1_cnt)) &&
          ((s1_lifm[i*WORD_WIDTH +: WORD_WIDTH] != '0) ||
           (s1_mt[i*ENTRY_W +: ENTRY_W] != '0)))
        chk_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (adv && s1_valid && chk_bad)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
